// File: rtl/ifu_fetch.sv
// ifu_fetch: credit-limited instruction fetch with a 2-entry {pc, ins} FIFO and redirect flush.
// Define IFU_ALIGN_CHK_EN to fault misaligned redirect targets into HALT and raise o_misalign.
module ifu_fetch #(
   parameter int                   CPU_WIDTH = 64,
   parameter int                   INS_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(64'h8000_0000)
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_stall,
   input  logic                 i_redirect,
   input  logic [CPU_WIDTH-1:0] i_redirect_pc,
   output logic                 o_imem_req_valid,
   input  logic                 i_imem_req_ready,
   output logic [CPU_WIDTH-1:0] o_imem_addr,
   input  logic                 i_imem_rsp_valid,
   input  logic [INS_WIDTH-1:0] i_imem_rsp_data,
   output logic                 o_if_valid,
   input  logic                 i_if_ready,
   output logic [INS_WIDTH-1:0] o_ifu_ins,
   output logic [CPU_WIDTH-1:0] o_ifu_pc,
   output logic                 o_misalign
);
`ifdef IFU_ALIGN_CHK_EN
   typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
`else
   typedef enum logic [1:0] {RUN, FLUSH} state_t;
`endif
   state_t               state_q, state_d;
   logic [CPU_WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
   logic [1:0]           osd_q, osd_d, drp_q, drp_d, cnt_q, cnt_d;
   logic                 wp_q, wp_d, rp_q, rp_d, held_q, held_d;
   logic                 new_req, hs, push, pop;
   logic [CPU_WIDTH-1:0] pc_mem_q  [2];
   logic [INS_WIDTH-1:0] ins_mem_q [2];
`ifdef IFU_ALIGN_CHK_EN
   logic bad, misalign_q, misalign_d;
   assign bad        = i_redirect_pc[1:0] != 2'b00;
   assign redir_pc   = i_redirect_pc;
   assign misalign_d = i_redirect ? bad : misalign_q;
   assign o_misalign = i_rst_n && misalign_q;
`else
   assign redir_pc   = i_redirect_pc & ~CPU_WIDTH'(3);
   assign o_misalign = 1'b0;
`endif
   always_comb begin
      new_req          = state_q == RUN && !i_stall && !i_redirect && ({1'b0, osd_q} + {1'b0, cnt_q} < 3'd2);
      o_imem_req_valid = i_rst_n && (held_q || new_req);
      o_imem_addr      = pc_q;
      hs               = o_imem_req_valid && i_imem_req_ready;
      push             = i_imem_rsp_valid && drp_q == 2'd0 && !i_redirect;
      o_if_valid       = i_rst_n && cnt_q != 2'd0;
      pop              = o_if_valid && i_if_ready && !i_redirect;
      o_ifu_ins        = o_if_valid ? ins_mem_q[rp_q] : '0;
      o_ifu_pc         = o_if_valid ? pc_mem_q[rp_q] : '0;
      // a raised request stays up through stalls; only a redirect abandons it
      held_d           = !i_redirect && o_imem_req_valid && !i_imem_req_ready;
      osd_d            = osd_q + 2'(hs) - 2'(i_imem_rsp_valid);
      drp_d            = i_redirect ? osd_d : (i_imem_rsp_valid && drp_q != 2'd0) ? drp_q - 2'd1 : drp_q;
      pc_d             = i_redirect ? redir_pc : hs ? pc_q + CPU_WIDTH'(4) : pc_q;
      rsp_pc_d         = i_redirect ? redir_pc : push ? rsp_pc_q + CPU_WIDTH'(4) : rsp_pc_q;
      cnt_d            = i_redirect ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
      wp_d             = i_redirect ? 1'b0 : wp_q ^ push;
      rp_d             = i_redirect ? 1'b0 : rp_q ^ pop;
      state_d          = i_redirect ? (osd_d != 2'd0 ? FLUSH : RUN) :
                         (state_q == FLUSH && drp_d == 2'd0) ? RUN : state_q;
`ifdef IFU_ALIGN_CHK_EN
      if (i_redirect && bad) state_d = HALT;
`endif
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         osd_q    <= 2'd0;
         drp_q    <= 2'd0;
         cnt_q    <= 2'd0;
         wp_q     <= 1'b0;
         rp_q     <= 1'b0;
         held_q   <= 1'b0;
`ifdef IFU_ALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         osd_q    <= osd_d;
         drp_q    <= drp_d;
         cnt_q    <= cnt_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         held_q   <= held_d;
`ifdef IFU_ALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end
   always_ff @(posedge i_clk) begin
      if (push) begin
         pc_mem_q[wp_q]  <= rsp_pc_q;
         ins_mem_q[wp_q] <= i_imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of ifu_fetch against a one-cycle in-order instruction memory.
// Memory returns ~addr[31:0] as the instruction; rsp_en holds responses back.
module tb_ifu_fetch;
   logic        clk = 1'b0;
   logic        rst_n, stall, redirect, req_valid, req_ready, rsp_valid, if_valid, if_ready, misalign, rsp_en;
   logic [63:0] redirect_pc, addr, pc;
   logic [31:0] rsp_data, ins;
   logic [63:0] mq[$];
   int          n_vec = 0;
   int          n_err = 0;

   ifu_fetch dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_addr(addr),
      .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
      .o_if_valid(if_valid), .i_if_ready(if_ready), .o_ifu_ins(ins), .o_ifu_pc(pc), .o_misalign(misalign)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         if (rsp_valid) void'(mq.pop_front());
         if (req_valid && req_ready) mq.push_back(addr);
         if (rsp_en && mq.size() > 0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= ~mq[0][31:0];
         end else rsp_valid <= 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 0; stall = 0; redirect = 0; redirect_pc = '0; req_ready = 1; if_ready = 1; rsp_en = 1;
      step(); step();
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_if_valid", 64'(if_valid), 64'd0);
      chk("rst_misalign", 64'(misalign), 64'd0);
      chk("rst_ins", 64'(ins), 64'd0);
      chk("rst_pc", pc, 64'd0);
      // in-order fetch after reset
      rst_n = 1; #1;
      chk("boot_req_valid", 64'(req_valid), 64'd1);
      chk("boot_addr", addr, 64'h8000_0000);
      step();
      chk("a1_addr", addr, 64'h8000_0004);
      chk("a1_if_valid", 64'(if_valid), 64'd0);
      step();
      chk("a2_if_valid", 64'(if_valid), 64'd1);
      chk("a2_pc", pc, 64'h8000_0000);
      chk("a2_ins", 64'(ins), 64'h7FFF_FFFF);
      chk("a2_credit_block", 64'(req_valid), 64'd0);
      step();
      chk("a3_pc", pc, 64'h8000_0004);
      chk("a3_req_valid", 64'(req_valid), 64'd1);
      chk("a3_addr", addr, 64'h8000_0008);
      step();
      chk("a4_if_valid", 64'(if_valid), 64'd0);
      step();
      chk("a5_pc", pc, 64'h8000_0008);
      // back-pressure from IF/ID fills the FIFO and stops requests
      if_ready = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_no_req", 64'(req_valid), 64'd0);
      end
      chk("bp_if_valid", 64'(if_valid), 64'd1);
      chk("bp_head_pc", pc, 64'h8000_0008);
      if_ready = 1;
      step();
      chk("bp_pop2_pc", pc, 64'h8000_000C);
      chk("bp_resume_valid", 64'(req_valid), 64'd1);
      chk("bp_resume_addr", addr, 64'h8000_0010);
      step(); step();
      chk("bp_next_pc", pc, 64'h8000_0010);
      chk("bp_next_ins", 64'(ins), 64'h7FFF_FFEF);
      // mid-operation reset, then redirect with two outstanding
      rst_n = 0;
      step();
      chk("mrst_req_valid", 64'(req_valid), 64'd0);
      chk("mrst_if_valid", 64'(if_valid), 64'd0);
      rsp_en = 0;
      step();
      rst_n = 1; #1;
      chk("mrst_addr", addr, 64'h8000_0000);
      step(); step();
      chk("osd2_no_req", 64'(req_valid), 64'd0);
      redirect = 1; redirect_pc = 64'h8000_0100; #1;
      chk("redir_cycle_no_req", 64'(req_valid), 64'd0);
      step();
      redirect = 0; #1;
      chk("flush_no_req", 64'(req_valid), 64'd0);
      chk("flush_if_valid", 64'(if_valid), 64'd0);
      step();
      chk("flush_hold", 64'(req_valid), 64'd0);
      rsp_en = 1;
      step();
      chk("flush_rsp_pending", 64'(req_valid), 64'd0);
      step();
      chk("flush_drop1_req", 64'(req_valid), 64'd0);
      chk("flush_drop1_ifv", 64'(if_valid), 64'd0);
      step();
      chk("flush_exit_valid", 64'(req_valid), 64'd1);
      chk("flush_exit_addr", addr, 64'h8000_0100);
      chk("flush_exit_ifv", 64'(if_valid), 64'd0);
      step();
      chk("redir_c8_ifv", 64'(if_valid), 64'd0);
      step();
      chk("redir_first_ifv", 64'(if_valid), 64'd1);
      chk("redir_first_pc", pc, 64'h8000_0100);
      chk("redir_first_ins", 64'(ins), 64'h7FFF_FEFF);
      // redirect coinciding with a held-request handshake and a pop
      if_ready = 0;
      step();
      chk("full_no_req", 64'(req_valid), 64'd0);
      if_ready = 1; req_ready = 0;
      step();
      chk("c11_pc", pc, 64'h8000_0104);
      chk("c11_valid", 64'(req_valid), 64'd1);
      chk("c11_addr", addr, 64'h8000_0108);
      if_ready = 0;
      step();
      chk("held_valid", 64'(req_valid), 64'd1);
      chk("held_addr", addr, 64'h8000_0108);
      chk("held_head", pc, 64'h8000_0104);
      redirect = 1; redirect_pc = 64'h8000_0300; req_ready = 1; if_ready = 1; #1;
      chk("hs_redir_valid", 64'(req_valid), 64'd1);
      step();
      redirect = 0; #1;
      chk("hs_redir_flushed", 64'(if_valid), 64'd0);
      chk("hs_redir_no_req", 64'(req_valid), 64'd0);
      step();
      chk("hs_redir_dropped", 64'(if_valid), 64'd0);
      chk("hs_redir_resume", 64'(req_valid), 64'd1);
      chk("hs_redir_addr", addr, 64'h8000_0300);
      step(); step();
      chk("hs_redir_pc", pc, 64'h8000_0300);
      // stall does not withdraw a raised request
      req_ready = 0;
      step();
      chk("st_raise_valid", 64'(req_valid), 64'd1);
      chk("st_raise_addr", addr, 64'h8000_0308);
      step();
      stall = 1; #1;
      chk("st_hold_valid", 64'(req_valid), 64'd1);
      chk("st_hold_addr", addr, 64'h8000_0308);
      step();
      chk("st_hold2_valid", 64'(req_valid), 64'd1);
      chk("st_hold2_addr", addr, 64'h8000_0308);
      req_ready = 1;
      step();
      chk("st_after_hs", 64'(req_valid), 64'd0);
      step();
      chk("st_no_new_req", 64'(req_valid), 64'd0);
      chk("st_rsp_pc", pc, 64'h8000_0308);
      // misaligned redirect target
      stall = 0; redirect = 1; redirect_pc = 64'h8000_0102;
      step();
      redirect = 0; redirect_pc = '0; #1;
`ifdef IFU_ALIGN_CHK_EN
      chk("mis_flag", 64'(misalign), 64'd1);
      chk("mis_no_req", 64'(req_valid), 64'd0);
`else
      chk("mis_flag", 64'(misalign), 64'd0);
      chk("mis_force_valid", 64'(req_valid), 64'd1);
      chk("mis_force_addr", addr, 64'h8000_0100);
`endif
      chk("mis_flushed", 64'(if_valid), 64'd0);
      redirect = 1; redirect_pc = 64'h8000_0200;
      step();
      redirect = 0; #1;
      chk("realign_flag", 64'(misalign), 64'd0);
      chk("realign_valid", 64'(req_valid), 64'd1);
      chk("realign_addr", addr, 64'h8000_0200);
      // PC wraps at the top of the address space
      step();
      redirect = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      redirect = 0; #1;
      chk("wrap_top_addr", addr, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_discard", 64'(if_valid), 64'd0);
      step();
      chk("wrap_valid", 64'(req_valid), 64'd1);
      chk("wrap_addr", addr, 64'd0);
      step();
      chk("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_ins", 64'(ins), 64'h0000_0003);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
